// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32 front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointer/count bookkeeping and a synchronous clear.
// The head word is read combinationally from storage, so it holds while no pop occurs.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   CAPACITY = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign do_pop_s  = pop_i && (count_q != {(AW + 1){1'b0}});
  assign do_push_s = push_i && ((count_q != CAPACITY) || do_pop_s);

  // Pointer wrap is explicit so non power-of-two depths also work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - (AW + 1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else if (clear_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests and
// buffers {pc, inst} pairs for IF/ID; redirects flush and drop wrong-path responses.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;
  localparam logic [IW-1:0] MAX_OUT_W = IW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_CAP   = TW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_W   = SW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [IW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   entry_count_s;
  logic [TW-1:0]   tag_count_s;
  logic [XLEN-1:0] tag_head_s;
  fetch_entry_t    entry_in_s, entry_head_s;
  logic            req_fire_s, entry_push_s, entry_pop_s, rsp_drop_s;
  logic [SW-1:0]   occupancy_s;

  // Outstanding requests reserve a FIFO slot, so an accepted response can never overflow.
  assign occupancy_s    = SW'(inflight_q) + SW'(entry_count_s);
  assign imem_req_valid = reset && !redirect_valid && (inflight_q < MAX_OUT_W) &&
                          (occupancy_s < DEPTH_W) && (tag_count_s < TAG_CAP);
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign rsp_drop_s   = imem_rsp_valid && (drop_q != {IW{1'b0}});
  assign entry_push_s = imem_rsp_valid && !rsp_drop_s && !redirect_valid &&
                        (tag_count_s != {TW{1'b0}});
  assign entry_in_s   = '{pc: tag_head_s, inst: imem_rsp_inst};

  assign out_valid   = reset && (entry_count_s != {CW{1'b0}}) && !redirect_valid;
  assign entry_pop_s = out_valid && out_ready;
  assign out_pc      = entry_head_s.pc;
  assign out_inst    = entry_head_s.inst;

  // Every response still in flight at a redirect is wrong-path and must be discarded.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      inflight_d = inflight_q - IW'(imem_rsp_valid);
      drop_d     = inflight_q - IW'(imem_rsp_valid);
    end else begin
      pc_d       = req_fire_s ? pc_q + 32'd4 : pc_q;
      inflight_d = inflight_q + IW'(req_fire_s) - IW'(imem_rsp_valid);
      drop_d     = rsp_drop_s ? drop_q - IW'(1) : drop_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= {IW{1'b0}};
      drop_q     <= {IW{1'b0}};
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (redirect_valid),
    .push_i      (entry_push_s),
    .push_data_i (entry_in_s),
    .pop_i       (entry_pop_s),
    .head_o      (entry_head_s),
    .count_o     (entry_count_s)
  );

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (redirect_valid),
    .push_i      (req_fire_s),
    .push_data_i (pc_q),
    .pop_i       (entry_push_s),
    .head_o      (tag_head_s),
    .count_o     (tag_count_s)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue against an in-order memory model and a
// queue-based model of the expected fetch stream.
module tb_if_fetch_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_inst = 32'h0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = 32'h0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  if_fetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        mq[$];
  ent_t        avail[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] exp_req_addr = 32'h0;
  logic [31:0] last_acc_addr = 32'h0;
  logic [31:0] first_pop_pc = 32'h0;
  logic [31:0] obs_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the models, advance the models.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic oready,
                      input logic rqready);
    req_t r;
    ent_t e;
    logic rsp_fire;
    logic exp_rv;
    int   outstanding;
    int   due;
    rsp_fire = 1'b0;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = oready;
    imem_req_ready = rqready;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      rsp_fire = 1'b1;
    end
    imem_rsp_valid = rsp_fire;
    imem_rsp_inst  = rsp_fire ? mem_word(r.addr) : $urandom();
    #1;
    outstanding = mq.size() + (rsp_fire ? 1 : 0);
    exp_rv = !redir && (outstanding < MAXO) && (outstanding + avail.size() < DEPTH);
    check_eq("req_valid", imem_req_valid, exp_rv);
    check_eq("out_valid", out_valid, (avail.size() != 0) && !redir);
    obs_addr = imem_req_addr;
    if (out_valid === 1'b1 && oready && avail.size() != 0) begin
      e = avail.pop_front();
      check_eq("out_pc", out_pc, e.pc);
      check_eq("out_inst", out_inst, e.inst);
      if (pop_cnt == 0) first_pop_pc = out_pc;
      pop_cnt++;
    end
    if (imem_req_valid === 1'b1 && rqready) begin
      check_eq("req_addr", imem_req_addr, exp_req_addr);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
      exp_req_addr = exp_req_addr + 32'd4;
      last_acc_addr = imem_req_addr;
      acc_cnt++;
    end
    if (rsp_fire && !redir && r.epoch == epoch) begin
      avail.push_back('{pc: r.addr, inst: mem_word(r.addr)});
    end
    if (redir) begin
      avail.delete();
      epoch++;
      exp_req_addr = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_pc", imem_req_addr, 32'h0);
    mq.delete();
    avail.delete();
    epoch++;
    exp_req_addr = 32'h0;
    last_due = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Stall from reset: FIFO fills, requests stop, head stays at pc 0.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("stall_head_pc", out_pc, 32'h0);
    check_eq("stall_req_valid", imem_req_valid, 1'b0);
    pop_cnt = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("drain_first_pc", first_pop_pc, 32'h0);
    check_eq("drain_enough", 32'(pop_cnt >= 8), 32'h1);

    // Two outstanding at L=3, then redirect.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("two_outstanding", mq.size(), 32'd2);
    pop_cnt = 0; first_pop_pc = 32'hDEAD_BEEF;
    step(1'b1, 32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 30 && pop_cnt == 0; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("redir_first_pc", first_pop_pc, 32'h100);

    // Redirect coincident with a response and out_ready.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !(mq.size() != 0 && mq[0].due <= cyc && avail.size() != 0); i++)
      step(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("coinc_setup", 32'(mq.size() != 0 && mq[0].due <= cyc), 32'h1);
    pop_cnt = 0; first_pop_pc = 32'hDEAD_BEEF;
    step(1'b1, 32'h200, 1'b1, 1'b1);
    check_eq("coinc_no_pop", pop_cnt, 32'd0);
    for (int i = 0; i < 30 && pop_cnt == 0; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("coinc_first_pc", first_pop_pc, 32'h200);

    // Misaligned redirect target and PC wrap.
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'h103, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("align_addr", obs_addr, 32'h100);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    acc_cnt = 0;
    for (int i = 0; i < 12 && acc_cnt < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("wrap_addr", last_acc_addr, 32'h0);

    // Fill the FIFO, then reset mid-stream and restart.
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("full_before_rst", avail.size(), 32'd4);
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 6 && acc_cnt < 1; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("restart_addr", last_acc_addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if (i % 500 == 0) begin
        lat_min = $urandom_range(3, 1);
        lat_max = lat_min + $urandom_range(3, 0);
      end
      if ($urandom_range(699, 0) == 0) do_reset();
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                        : $urandom();
      step(32'($urandom_range(99, 0)) < 32'd4, rpc,
           32'($urandom_range(99, 0)) < 32'd60, 32'($urandom_range(99, 0)) < 32'd75);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
